// File: rtl/fetch_target_queue.sv
// Fetch target queue: circular buffer of predicted fetch blocks sitting
// between the branch predictor, the fetch unit and the backend. Entries are
// enqueued by the BPU, handed to fetch in order, patched by branch writeback
// and squash, and retired at commit, at which point they train the BPU.
module fetch_target_queue #(
    parameter  int FTQ_SIZE = 16,
    parameter  int READ_NUM = 4,
    parameter  int BRU_NUM  = 2,
    parameter  int XLEN     = 64,
    localparam int IW       = $clog2(FTQ_SIZE)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_pred_vld,
    output logic            o_pred_rdy,
    input  logic [XLEN-1:0] i_pred_startAddr,
    input  logic [XLEN-1:0] i_pred_nextAddr,
    output logic            o_fetch_vld,
    input  logic            i_fetch_rdy,
    output logic [IW-1:0]   o_fetch_ftqIdx,
    output logic [XLEN-1:0] o_fetch_startAddr,
    output logic [XLEN-1:0] o_fetch_nextAddr,
    input  logic [IW-1:0]   i_read_ftqIdx       [READ_NUM],
    output logic [XLEN-1:0] o_read_ftqStartAddr [READ_NUM],
    output logic [XLEN-1:0] o_read_ftqNextAddr  [READ_NUM],
    input  logic [BRU_NUM-1:0] i_branchwb_vld,
    input  logic [IW-1:0]   i_branchwb_ftqIdx   [BRU_NUM],
    input  logic            i_branchwb_mispred  [BRU_NUM],
    input  logic [XLEN-1:0] i_branchwb_npc      [BRU_NUM],
    input  logic            i_commit_ftq_vld,
    input  logic [IW-1:0]   i_commit_ftqIdx,
    input  logic            i_squash_vld,
    input  logic [IW-1:0]   i_squash_ftqIdx,
    input  logic [XLEN-1:0] i_squash_npc,
    output logic            o_redirect_vld,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic            o_update_vld,
    output logic            o_update_mispred,
    output logic [XLEN-1:0] o_update_startAddr,
    output logic [XLEN-1:0] o_update_nextAddr,
    output logic [IW:0]     o_count,
    output logic            o_commit_err
);

    localparam logic [IW:0] PTR_ONE = (IW+1)'(1);

    // Pointers carry a wrap bit above the index so full and empty differ
    logic [IW:0]         r_head, r_fetch, r_tail;
    logic [XLEN-1:0]     r_startArr [FTQ_SIZE];
    logic [XLEN-1:0]     r_nextArr  [FTQ_SIZE];
    logic [FTQ_SIZE-1:0] r_mispred;
    logic                r_commitErr;
    logic                r_redirectVld;
    logic [XLEN-1:0]     r_redirectPc;
    logic                r_updateVld, r_updateMispred;
    logic [XLEN-1:0]     r_updateStart, r_updateNext;

    logic                w_empty, w_full, w_enq, w_deq;
    logic                w_commitOk, w_commitBad;
    logic                w_squashWrap;
    logic [IW:0]         w_squashTail;
    logic [FTQ_SIZE-1:0] w_mispredNext;
    logic [XLEN-1:0]     w_headNext;
    logic                w_headMisp;

    assign w_empty     = (r_head == r_tail);
    assign w_full      = (r_head[IW-1:0] == r_tail[IW-1:0]) && (r_head[IW] != r_tail[IW]);
    assign o_pred_rdy  = !w_full && !i_squash_vld;
    assign w_enq       = i_pred_vld && o_pred_rdy;
    assign o_fetch_vld = (r_fetch != r_tail) && !i_squash_vld;
    assign w_deq       = o_fetch_vld && i_fetch_rdy;

    assign o_fetch_ftqIdx    = r_fetch[IW-1:0];
    assign o_fetch_startAddr = r_startArr[r_fetch[IW-1:0]];
    assign o_fetch_nextAddr  = r_nextArr[r_fetch[IW-1:0]];

    assign w_commitOk  = i_commit_ftq_vld && !w_empty;
    assign w_commitBad = i_commit_ftq_vld && (w_empty || (i_commit_ftqIdx != r_head[IW-1:0]));

    // A squash index below the head index lies in the other lap of the ring
    assign w_squashWrap = (i_squash_ftqIdx >= r_head[IW-1:0]) ? r_head[IW] : ~r_head[IW];
    assign w_squashTail = {w_squashWrap, i_squash_ftqIdx} + PTR_ONE;

    assign o_count            = r_tail - r_head;
    assign o_commit_err       = r_commitErr;
    assign o_redirect_vld     = r_redirectVld;
    assign o_redirect_pc      = r_redirectPc;
    assign o_update_vld       = r_updateVld;
    assign o_update_mispred   = r_updateMispred;
    assign o_update_startAddr = r_updateStart;
    assign o_update_nextAddr  = r_updateNext;

    // Backend read ports look straight into the stored array contents
    always_comb begin
        for (int r = 0; r < READ_NUM; r++) begin
            o_read_ftqStartAddr[r] = r_startArr[i_read_ftqIdx[r]];
            o_read_ftqNextAddr[r]  = r_nextArr[i_read_ftqIdx[r]];
        end
    end

    // Next mispredict flags: enqueue clears, branchwb accumulates, squash forces
    always_comb begin
        w_mispredNext = r_mispred;
        if (w_enq) begin
            w_mispredNext[r_tail[IW-1:0]] = 1'b0;
        end
        for (int p = 0; p < BRU_NUM; p++) begin
            if (i_branchwb_vld[p]) begin
                w_mispredNext[i_branchwb_ftqIdx[p]] =
                    w_mispredNext[i_branchwb_ftqIdx[p]] | i_branchwb_mispred[p];
            end
        end
        if (i_squash_vld) begin
            w_mispredNext[i_squash_ftqIdx] = 1'b1;
        end
    end

    // Head entry as it will look after this edge, so training sees same-cycle writes
    always_comb begin
        w_headNext = r_nextArr[r_head[IW-1:0]];
        for (int p = 0; p < BRU_NUM; p++) begin
            if (i_branchwb_vld[p] && (i_branchwb_ftqIdx[p] == r_head[IW-1:0])) begin
                w_headNext = i_branchwb_npc[p];
            end
        end
        if (i_squash_vld && (i_squash_ftqIdx == r_head[IW-1:0])) begin
            w_headNext = i_squash_npc;
        end
        w_headMisp = w_mispredNext[r_head[IW-1:0]];
    end

    // Address storage; later writes win, so higher branch ports and then squash take priority
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_startArr[r_tail[IW-1:0]] <= i_pred_startAddr;
            r_nextArr[r_tail[IW-1:0]]  <= i_pred_nextAddr;
        end
        for (int p = 0; p < BRU_NUM; p++) begin
            if (i_branchwb_vld[p]) begin
                r_nextArr[i_branchwb_ftqIdx[p]] <= i_branchwb_npc[p];
            end
        end
        if (i_squash_vld) begin
            r_nextArr[i_squash_ftqIdx] <= i_squash_npc;
        end
    end

    // Queue pointers, mispredict flags and the sticky commit error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head      <= '0;
            r_fetch     <= '0;
            r_tail      <= '0;
            r_mispred   <= '0;
            r_commitErr <= 1'b0;
        end else begin
            r_mispred   <= w_mispredNext;
            r_commitErr <= r_commitErr | w_commitBad;
            if (w_commitOk) begin
                r_head <= r_head + PTR_ONE;
            end
            if (i_squash_vld) begin
                r_tail  <= w_squashTail;
                r_fetch <= w_squashTail;
            end else begin
                if (w_enq) begin
                    r_tail <= r_tail + PTR_ONE;
                end
                if (w_deq) begin
                    r_fetch <= r_fetch + PTR_ONE;
                end
            end
        end
    end

    // One-cycle redirect pulse to the BPU and training record of the retired entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_redirectVld   <= 1'b0;
            r_redirectPc    <= '0;
            r_updateVld     <= 1'b0;
            r_updateMispred <= 1'b0;
            r_updateStart   <= '0;
            r_updateNext    <= '0;
        end else begin
            r_redirectVld <= i_squash_vld;
            if (i_squash_vld) begin
                r_redirectPc <= i_squash_npc;
            end
            r_updateVld <= w_commitOk;
            if (w_commitOk) begin
                r_updateMispred <= w_headMisp;
                r_updateStart   <= r_startArr[r_head[IW-1:0]];
                r_updateNext    <= w_headNext;
            end
        end
    end

endmodule

// File: doc/fetch_target_queue.md
FETCH_TARGET_QUEUE -- requirements
Module: fetch_target_queue

Interface
REQ-001 SHALL have parameter FTQ_SIZE, default 16, entry count (power of 2, >=4).
REQ-002 SHALL have parameter READ_NUM, default 4, backend address read ports (BRU+LDU+STU).
REQ-003 SHALL have parameter BRU_NUM, default 2, branch writeback ports.
REQ-004 SHALL have parameter XLEN, default 64, address width.
REQ-005 SHALL have the following ports; IW = $clog2(FTQ_SIZE):
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_pred_vld / o_pred_rdy  in/out  1/1  BPU enqueue handshake.
- i_pred_startAddr, i_pred_nextAddr  in  XLEN  predicted fetch block and its successor.
- o_fetch_vld / i_fetch_rdy  out/in  1/1  fetch-side dequeue handshake.
- o_fetch_ftqIdx  out  IW; o_fetch_startAddr, o_fetch_nextAddr  out  XLEN.
- i_read_ftqIdx[READ_NUM]  in  IW; o_read_ftqStartAddr[READ_NUM], o_read_ftqNextAddr[READ_NUM]  out  XLEN.
- i_branchwb_vld  in  BRU_NUM; i_branchwb_ftqIdx[BRU_NUM]  in  IW; i_branchwb_mispred[BRU_NUM]  in  1; i_branchwb_npc[BRU_NUM]  in  XLEN.
- i_commit_ftq_vld  in  1; i_commit_ftqIdx  in  IW  retire oldest entry.
- i_squash_vld  in  1; i_squash_ftqIdx  in  IW; i_squash_npc  in  XLEN.
- o_redirect_vld  out  1; o_redirect_pc  out  XLEN  BPU restart.
- o_update_vld, o_update_mispred  out  1; o_update_startAddr, o_update_nextAddr  out  XLEN  BPU training.
- o_count  out  IW+1  occupancy; o_commit_err  out  1  sticky commit-index mismatch.

Function
REQ-006 SHALL hold head, fetch, tail pointers of IW bits plus wrap bit each; empty = head==tail, full = index equal with wrap differing.
REQ-007 SHALL drive o_pred_rdy = !full && !i_squash_vld; on vld&&rdy write startAddr, nextAddr, clear mispred at tail, tail+1 with wrap toggle at FTQ_SIZE-1.
REQ-008 SHALL drive o_fetch_vld = (fetch != tail) && !i_squash_vld, presenting entry at fetch combinationally; vld&&rdy advances fetch by 1.
REQ-009 SHALL make an entry enqueued in cycle N visible to fetch in cycle N+1 (no bypass).
REQ-010 SHALL serve read ports combinationally from array state, no write bypass; any index in range is legal.
REQ-011 SHALL, per valid branchwb port, write nextAddr = npc and mispred |= i_branchwb_mispred at ftqIdx on the next edge; same-index ports in one cycle: higher port number wins.
REQ-012 SHALL, on i_commit_ftq_vld, free entry head and advance head by 1; if i_commit_ftqIdx != head index set o_commit_err (cleared only by reset); commit on empty queue ignored and sets o_commit_err.
REQ-013 SHALL register o_update_* one cycle after commit with freed entry contents, including any same-cycle branchwb to it.
REQ-014 SHALL on i_squash_vld: new tail = squash entry + 1, tail wrap = head wrap if i_squash_ftqIdx >= head index else inverted head wrap, carry applied on increment; fetch = new tail; entry nextAddr = i_squash_npc, mispred = 1.
REQ-015 SHALL give squash nextAddr write priority over same-cycle branchwb to same index.
REQ-016 SHALL apply same-cycle commit normally with squash; enqueue suppressed by REQ-007.
REQ-017 SHALL assert o_redirect_vld for exactly one cycle, the cycle after i_squash_vld, with o_redirect_pc = registered i_squash_npc; back-to-back squashes give back-to-back pulses, last value each cycle.
REQ-018 SHALL output o_count = tail - head including wrap bits, registered state only.
REQ-019 SHALL tolerate simultaneous enqueue, fetch, commit, branchwb in one cycle, updating all pointers independently.

Reset
REQ-020 SHALL, on rst low asynchronously, clear all pointers and wrap bits, mispred bits, o_commit_err, o_redirect_vld, o_update_vld; o_pred_rdy=1, o_fetch_vld=0, o_count=0; address arrays not reset.
REQ-021 SHALL, on rst assertion mid-operation, discard all entries; first enqueue after release lands at index 0.

Verification
REQ-022 SHALL pass: 16 enqueues, no fetch -> o_count=16, o_pred_rdy=0; one commit -> o_pred_rdy=1 next cycle, o_count=15.
REQ-023 SHALL pass: enqueue start 0x1000/next 0x1040 at idx 0 -> o_fetch_vld=1, idx 0, addrs 0x1000/0x1040 next cycle; read port 2 idx 0 returns same.
REQ-024 SHALL pass: entries 0..5, fetch at 6, squash idx 2 npc 0x2000 -> o_count=3, o_fetch_vld=0, o_redirect_vld=1 with pc 0x2000 next cycle, entry 2 nextAddr reads 0x2000.
REQ-025 SHALL pass: head=14 wrap 0, tail=4 wrap 1, squash idx 1 -> tail=2 wrap 1, o_count=4.
REQ-026 SHALL pass: branchwb ports 0,1 both idx 3, npc 0xA0/0xB0 mispred 1 -> entry 3 nextAddr 0xB0; commit idx 3 at head -> o_update_mispred=1, o_update_nextAddr=0xB0.
REQ-027 SHALL pass: commit idx 5 while head=4 -> o_commit_err=1 sticky until rst low.
